adc_log_ctrl: RTL and testbench

Controller that sequences the on-chip temperature ADC and its sample RAM. After PLL lock it writes the sequencer control/status register (CSR) to start continuous conversion. It then box-car averages 2^AVG_LOG2 valid ADC responses and writes each average into the RAM at a circular address. A watchdog stops and restarts the sequencer when the ADC stops producing responses.

---
 rtl/adc_log_ctrl.sv | 169 ++++++++++++++++
 tb/tb_adc_log_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_log_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_log_ctrl: starts the ADC sequencer, box-car averages its samples      |
// | into a circular RAM log, and restarts the sequencer when samples stall.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module adc_log_ctrl #(
    parameter int AVG_LOG2 = 2,
    parameter int ADDR_W   = 3,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              enable,
    input  logic              adc_valid,
    input  logic [11:0]       adc_data,
    output logic              csr_write,
    output logic              csr_address,
    output logic [31:0]       csr_writedata,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [11:0]       ram_data,
    output logic [11:0]       avg_out,
    output logic              avg_valid,
    output logic              wrapped,
    output logic [7:0]        restart_cnt
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] N_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CFG   = 3'd1,
        S_RUN   = 3'd2,
        S_WRITE = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               wrapped_q, wrapped_d;
    logic [11:0]        avg_q, avg_d;
    logic               tocause_q, tocause_d;
    logic [7:0]         rcnt_q, rcnt_d;

    logic [ACC_W-1:0]   sum;
    logic [11:0]        sum_avg;
    logic               run_ok;

    assign sum     = acc_q + ACC_W'(adc_data);
    assign sum_avg = sum[ACC_W-1:AVG_LOG2];
    assign run_ok  = pll_locked & enable;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        ptr_d     = ptr_q;
        wrapped_d = wrapped_q;
        avg_d     = avg_q;
        tocause_d = tocause_q;
        rcnt_d    = rcnt_q;
        case (state_q)
            S_IDLE: begin
                if (run_ok) state_d = S_CFG;
            end
            S_CFG: begin
                acc_d   = '0;
                cnt_d   = '0;
                tmr_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // Loss of run conditions outranks a completing sample.
                if (!run_ok) begin
                    acc_d     = '0;
                    cnt_d     = '0;
                    tocause_d = 1'b0;
                    state_d   = S_STOP;
                end else if (adc_valid) begin
                    tmr_d = '0;
                    if (cnt_q == N_LAST) begin
                        avg_d   = sum_avg;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (tmr_q == TMR_LAST) begin
                    tocause_d = 1'b1;
                    state_d   = S_STOP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WRITE: begin
                ptr_d   = ptr_q + ADDR_W'(1);
                tmr_d   = '0;
                state_d = S_RUN;
                if (&ptr_q) wrapped_d = 1'b1;
                // A sample landing in the write cycle opens the next window;
                // with a single-sample window it completes that window at once.
                if (adc_valid) begin
                    if (N_LAST == '0) begin
                        avg_d   = sum_avg;
                        state_d = S_WRITE;
                    end else begin
                        acc_d = sum;
                        cnt_d = CNT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (tocause_q && rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
                tocause_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            ptr_q     <= '0;
            wrapped_q <= 1'b0;
            avg_q     <= '0;
            tocause_q <= 1'b0;
            rcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            ptr_q     <= ptr_d;
            wrapped_q <= wrapped_d;
            avg_q     <= avg_d;
            tocause_q <= tocause_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign csr_write     = (state_q == S_CFG) || (state_q == S_STOP);
    assign csr_address   = 1'b0;
    assign csr_writedata = (state_q == S_CFG) ? 32'h0000_0003 : 32'h0;
    assign ram_wren      = (state_q == S_WRITE);
    assign ram_addr      = ptr_q;
    assign ram_data      = avg_q;
    assign avg_out       = avg_q;
    assign avg_valid     = (state_q == S_WRITE);
    assign wrapped       = wrapped_q;
    assign restart_cnt   = rcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_log_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adc_log_ctrl: directed self-checking bench for adc_log_ctrl.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_adc_log_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pll_locked = 1'b1;
    logic        enable = 1'b1;
    logic        adc_valid = 1'b0;
    logic [11:0] adc_data = '0;
    logic        csr_write;
    logic        csr_address;
    logic [31:0] csr_writedata;
    logic        ram_wren;
    logic [2:0]  ram_addr;
    logic [11:0] ram_data;
    logic [11:0] avg_out;
    logic        avg_valid;
    logic        wrapped;
    logic [7:0]  restart_cnt;

    int checks = 0;
    int failures = 0;
    logic [2:0] exp_ptr = '0;
    logic       exp_wrapped = 1'b0;

    adc_log_ctrl #(.AVG_LOG2(2), .ADDR_W(3), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .enable       (enable),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .csr_write    (csr_write),
        .csr_address  (csr_address),
        .csr_writedata(csr_writedata),
        .ram_wren     (ram_wren),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .wrapped      (wrapped),
        .restart_cnt  (restart_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] d);
        adc_valid = 1'b1;
        adc_data  = d;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({csr_write, csr_address, csr_writedata, ram_wren, ram_addr, ram_data,
             avg_out, avg_valid, wrapped, restart_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got csr_w=%b data=%h wren=%b addr=%0d avg=%h rc=%0d required all zero",
                     csr_write, csr_writedata, ram_wren, ram_addr, avg_out, restart_cnt);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (csr_write !== 1'b1 || csr_writedata !== 32'h3 || csr_address !== 1'b0) begin
            failures++;
            $display("FAIL cfg_strobe: got csr_w=%b data=%h addr=%b required 1/00000003/0",
                     csr_write, csr_writedata, csr_address);
        end
        tick();
        checks++;
        if (csr_write !== 1'b0) begin
            failures++;
            $display("FAIL cfg_one_cycle: got csr_w=%b required 0", csr_write);
        end
    endtask

    task automatic test_average();
        send(12'd100);
        send(12'd101);
        send(12'd102);
        checks++;
        if (ram_wren !== 1'b0) begin
            failures++;
            $display("FAIL early_write: got wren=%b required 0", ram_wren);
        end
        send(12'd103);
        checks++;
        if (ram_wren !== 1'b1 || ram_addr !== 3'd0 || ram_data !== 12'd101 ||
            avg_out !== 12'd101 || avg_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_avg: got wren=%b addr=%0d data=%0d avg=%0d vld=%b required 1/0/101/101/1",
                     ram_wren, ram_addr, ram_data, avg_out, avg_valid);
        end
        exp_ptr++;
        tick();
        checks++;
        if (ram_wren !== 1'b0 || avg_valid !== 1'b0 || avg_out !== 12'd101) begin
            failures++;
            $display("FAIL avg_hold: got wren=%b vld=%b avg=%0d required 0/0/101",
                     ram_wren, avg_valid, avg_out);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) begin
            logic [11:0] a;
            a = 12'(i * 40 + 7);
            send(a);
            send(a + 12'd1);
            send(a + 12'd2);
            send(a + 12'd5);
            checks++;
            if (ram_wren !== 1'b1 || ram_addr !== exp_ptr || ram_data !== a + 12'd2) begin
                failures++;
                $display("FAIL wrap_write[%0d]: got wren=%b addr=%0d data=%0d required 1/%0d/%0d",
                         i, ram_wren, ram_addr, ram_data, exp_ptr, a + 12'd2);
            end
            if (exp_ptr == 3'd7) exp_wrapped = 1'b1;
            exp_ptr++;
            tick();
            checks++;
            if (wrapped !== exp_wrapped) begin
                failures++;
                $display("FAIL wrapped_flag[%0d]: got %b required %b", i, wrapped, exp_wrapped);
            end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (csr_write !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: got csr_w=%b required 0 after 15 idle cycles", csr_write);
        end
        tick();
        checks++;
        if (csr_write !== 1'b1 || csr_writedata !== 32'h0) begin
            failures++;
            $display("FAIL timeout_stop: got csr_w=%b data=%h required 1/00000000",
                     csr_write, csr_writedata);
        end
        adc_valid = 1'b1;
        adc_data  = 12'hABC;
        tick();
        checks++;
        if (csr_write !== 1'b0 || restart_cnt !== 8'd1) begin
            failures++;
            $display("FAIL restart_count: got csr_w=%b rc=%0d required 0/1", csr_write, restart_cnt);
        end
        adc_valid = 1'b0;
        tick();
        checks++;
        if (csr_write !== 1'b1 || csr_writedata !== 32'h3) begin
            failures++;
            $display("FAIL restart_cfg: got csr_w=%b data=%h required 1/00000003",
                     csr_write, csr_writedata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        send(12'hFFF);
        send(12'hFFF);
        send(12'hFFF);
        checks++;
        if (ram_wren !== 1'b0) begin
            failures++;
            $display("FAIL stop_samples_ignored: got wren=%b required 0", ram_wren);
        end
        adc_valid = 1'b1;
        adc_data  = 12'hFFF;
        tick();
        checks++;
        if (ram_wren !== 1'b1 || ram_addr !== exp_ptr || ram_data !== 12'hFFF) begin
            failures++;
            $display("FAIL full_scale: got wren=%b addr=%0d data=%h required 1/%0d/fff",
                     ram_wren, ram_addr, ram_data, exp_ptr);
        end
        exp_ptr++;
        adc_data = 12'h010;
        tick();
        adc_valid = 1'b0;
        send(12'h010);
        send(12'h010);
        checks++;
        if (ram_wren !== 1'b0) begin
            failures++;
            $display("FAIL b2b_early: got wren=%b required 0", ram_wren);
        end
        send(12'h010);
        checks++;
        if (ram_wren !== 1'b1 || ram_addr !== exp_ptr || ram_data !== 12'h010) begin
            failures++;
            $display("FAIL b2b_window: got wren=%b addr=%0d data=%h required 1/%0d/010",
                     ram_wren, ram_addr, ram_data, exp_ptr);
        end
        exp_ptr++;
        tick();
    endtask

    task automatic test_async_reset();
        send(12'd5);
        send(12'd6);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ram_addr !== 3'd0 || avg_out !== 12'd0 || ram_data !== 12'd0 ||
            wrapped !== 1'b0 || restart_cnt !== 8'd0 || csr_write !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got addr=%0d avg=%h wrapped=%b rc=%0d csr_w=%b required all zero",
                     ram_addr, avg_out, wrapped, restart_cnt, csr_write);
        end
        exp_ptr = '0;
        exp_wrapped = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        send(12'd20);
        send(12'd20);
        send(12'd20);
        send(12'd24);
        checks++;
        if (ram_wren !== 1'b1 || ram_addr !== 3'd0 || ram_data !== 12'd21 || wrapped !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_write: got wren=%b addr=%0d data=%0d wrapped=%b required 1/0/21/0",
                     ram_wren, ram_addr, ram_data, wrapped);
        end
        exp_ptr++;
        tick();
    endtask

    task automatic test_enable_drop();
        send(12'd300);
        send(12'd300);
        enable = 1'b0;
        tick();
        checks++;
        if (csr_write !== 1'b1 || csr_writedata !== 32'h0 || ram_wren !== 1'b0) begin
            failures++;
            $display("FAIL enable_stop: got csr_w=%b data=%h wren=%b required 1/00000000/0",
                     csr_write, csr_writedata, ram_wren);
        end
        tick();
        checks++;
        if (restart_cnt !== 8'd0 || ram_wren !== 1'b0 || csr_write !== 1'b0) begin
            failures++;
            $display("FAIL enable_no_count: got rc=%0d wren=%b csr_w=%b required 0/0/0",
                     restart_cnt, ram_wren, csr_write);
        end
        enable = 1'b1;
        tick();
        tick();
        send(12'd40);
        send(12'd40);
        checks++;
        if (ram_wren !== 1'b0) begin
            failures++;
            $display("FAIL partial_discard: got wren=%b required 0", ram_wren);
        end
        send(12'd40);
        send(12'd44);
        checks++;
        if (ram_wren !== 1'b1 || ram_addr !== exp_ptr || ram_data !== 12'd41) begin
            failures++;
            $display("FAIL resume_write: got wren=%b addr=%0d data=%0d required 1/%0d/41",
                     ram_wren, ram_addr, ram_data, exp_ptr);
        end
        exp_ptr++;
        tick();
        send(12'd1);
        send(12'd2);
        send(12'd3);
        pll_locked = 1'b0;
        send(12'd4);
        checks++;
        if (csr_write !== 1'b1 || csr_writedata !== 32'h0 || ram_wren !== 1'b0) begin
            failures++;
            $display("FAIL lock_priority: got csr_w=%b data=%h wren=%b required 1/00000000/0",
                     csr_write, csr_writedata, ram_wren);
        end
        pll_locked = 1'b1;
        tick();
        checks++;
        if (restart_cnt !== 8'd0 || ram_addr !== exp_ptr) begin
            failures++;
            $display("FAIL lock_retention: got rc=%0d addr=%0d required 0/%0d",
                     restart_cnt, ram_addr, exp_ptr);
        end
    endtask

    initial begin
        test_reset();
        test_average();
        test_wrap();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_enable_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
